clock_set_controller: RTL

Mode/setting sequencer for the digital clock datapath. Takes debounced key pulses and the 10 ms tick, then drives the display status code and one-cycle increment requests to the minute/hour/day/month counters. It also drives the seconds run-enable, a seconds-clear pulse, and the blinking digit-enable mask for the segment scanner. It sits between the key debouncers and the time counters, and separates the month and day increment paths.

---
 rtl/clock_pkg.sv | 33 +++
 rtl/key_repeat.sv | 62 ++++++
 rtl/clock_set_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and default timing for the clock set-mode controller.
// Timing values are in 10 ms ticks.
package clock_pkg;

  typedef enum logic [2:0] {
    STATUS_TIME   = 3'd0,
    STATUS_HOUR   = 3'd1,
    STATUS_MINUTE = 3'd2,
    STATUS_MONTH  = 3'd3,
    STATUS_DAY    = 3'd4
  } status_e;

  localparam logic [3:0] MASK_ALL   = 4'b1111;
  localparam logic [3:0] MASK_LEFT  = 4'b1100;
  localparam logic [3:0] MASK_RIGHT = 4'b0011;
  localparam logic [3:0] MASK_NONE  = 4'b0000;

  localparam int REPEAT_DELAY_DEF = 50;
  localparam int REPEAT_RATE_DEF  = 10;
  localparam int TIMEOUT_DEF      = 3000;
  localparam int BLINK_HALF_DEF   = 25;

  function automatic status_e next_status(input status_e s);
    case (s)
      STATUS_TIME:   next_status = STATUS_HOUR;
      STATUS_HOUR:   next_status = STATUS_MINUTE;
      STATUS_MINUTE: next_status = STATUS_MONTH;
      STATUS_MONTH:  next_status = STATUS_DAY;
      default:       next_status = STATUS_TIME;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Add-key auto-repeat: counts held ticks, fires once at REPEAT_DELAY and then
// every REPEAT_RATE ticks. repeat_pulse is combinational; the parent registers it.
module key_repeat
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic level,
  input  logic clear,
  output logic repeat_pulse
);

  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(REPEAT_DELAY);
  localparam logic [RATE_W-1:0] RATE_RELOAD = RATE_W'(REPEAT_RATE - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [RATE_W-1:0] rate_q, rate_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      rate_q <= '0;
    end else begin
      hold_q <= hold_d;
      rate_q <= rate_d;
    end
  end

  // Once the hold count saturates, the rate down-counter alone paces the pulses.
  always_comb begin
    hold_d       = hold_q;
    rate_d       = rate_q;
    repeat_pulse = 1'b0;
    if (clear || !level) begin
      hold_d = '0;
      rate_d = '0;
    end else if (tick) begin
      if (hold_q == HOLD_SAT) begin
        if (rate_q == '0) begin
          repeat_pulse = 1'b1;
          rate_d       = RATE_RELOAD;
        end else begin
          rate_d = rate_q - RATE_W'(1);
        end
      end else begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_FIRST) begin
          repeat_pulse = 1'b1;
          rate_d       = RATE_RELOAD;
        end
      end
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Set-mode sequencer for the clock: mode/add keys to status, increment pulses,
// seconds run/clear and blinking digit mask.
//   state          | meaning
//   STATUS_TIME    | normal time display, seconds running
//   STATUS_HOUR    | adjusting hours (left pair blinks)
//   STATUS_MINUTE  | adjusting minutes (right pair blinks)
//   STATUS_MONTH   | adjusting month (left pair blinks)
//   STATUS_DAY     | adjusting day (right pair blinks)
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int BLINK_HALF   = BLINK_HALF_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_10ms,
  input  logic       key_mode_press,
  input  logic       key_add_press,
  input  logic       key_add_level,
  output logic [2:0] status,
  output logic       inc_minute,
  output logic       inc_hour,
  output logic       inc_day,
  output logic       inc_month,
  output logic       clock_run,
  output logic       second_clear,
  output logic [3:0] digit_mask
);

  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  status_e            status_q, status_d;
  logic [3:0]         inc_q, inc_d;
  logic               clock_run_q, clock_run_d;
  logic               second_clear_q, second_clear_d;
  logic [3:0]         digit_mask_q, digit_mask_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic status_legal, in_set, status_chg, timeout_hit, rpt_clear, repeat_pulse, visible;

  assign status_legal = (status_q <= STATUS_DAY);
  assign in_set       = status_legal && (status_q != STATUS_TIME);

  always_comb begin
    status_d    = status_q;
    timeout_hit = in_set && tick_10ms && (idle_q == IDLE_LAST)
                  && !key_mode_press && !key_add_press;
    if (!status_legal)       status_d = STATUS_TIME;
    else if (key_mode_press) status_d = next_status(status_q);
    else if (timeout_hit)    status_d = STATUS_TIME;
  end

  assign status_chg = (status_d != status_q);
  assign rpt_clear  = status_chg || !in_set;

  key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_key_repeat (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick_10ms),
    .level       (key_add_level),
    .clear       (rpt_clear),
    .repeat_pulse(repeat_pulse)
  );

  always_comb begin
    inc_d          = '0;
    clock_run_d    = clock_run_q;
    second_clear_d = 1'b0;
    idle_d         = idle_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    digit_mask_d   = MASK_ALL;

    // Manual press and repeat pulse merge into one request; a mode change suppresses both.
    if (!status_chg && in_set && (key_add_press || repeat_pulse)) begin
      case (status_q)
        STATUS_MINUTE: inc_d[0] = 1'b1;
        STATUS_HOUR:   inc_d[1] = 1'b1;
        STATUS_DAY:    inc_d[2] = 1'b1;
        STATUS_MONTH:  inc_d[3] = 1'b1;
        default:       inc_d    = '0;
      endcase
    end

    if (status_chg && (status_d == STATUS_TIME)) begin
      clock_run_d    = 1'b1;
      second_clear_d = !clock_run_q;
    end else if (|inc_d) begin
      clock_run_d = 1'b0;
    end

    if (status_chg || key_mode_press || key_add_press) idle_d = '0;
    else if (tick_10ms && in_set)                      idle_d = idle_q + IDLE_W'(1);

    if (status_chg) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (tick_10ms) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    visible = blink_phase_d || key_add_level;
    case (status_d)
      STATUS_HOUR, STATUS_MONTH:  digit_mask_d = visible ? MASK_LEFT  : MASK_NONE;
      STATUS_MINUTE, STATUS_DAY:  digit_mask_d = visible ? MASK_RIGHT : MASK_NONE;
      default:                    digit_mask_d = MASK_ALL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_q       <= STATUS_TIME;
      inc_q          <= '0;
      clock_run_q    <= 1'b1;
      second_clear_q <= 1'b0;
      digit_mask_q   <= MASK_ALL;
      idle_q         <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b1;
    end else begin
      status_q       <= status_d;
      inc_q          <= inc_d;
      clock_run_q    <= clock_run_d;
      second_clear_q <= second_clear_d;
      digit_mask_q   <= digit_mask_d;
      idle_q         <= idle_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
    end
  end

  assign status       = status_q;
  assign inc_minute   = inc_q[0];
  assign inc_hour     = inc_q[1];
  assign inc_day      = inc_q[2];
  assign inc_month    = inc_q[3];
  assign clock_run    = clock_run_q;
  assign second_clear = second_clear_q;
  assign digit_mask   = digit_mask_q;

endmodule
